// File: rtl/riscv_pkg.sv
// Shared types for the hazard scheduler:
// forward selects, FSM states and per-stage records.
package riscv_pkg;

    localparam int MAX_REGW = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic                valid;
        logic [MAX_REGW-1:0] rs1;
        logic [MAX_REGW-1:0] rs2;
        logic [MAX_REGW-1:0] rd;
        logic                regwrite;
        logic                memread;
    } stage_info_t;

endpackage

// File: rtl/fwd_sel_unit.sv
// Forward select for one ALU operand.
// MEM beats WB; x0 never forwards.
module fwd_sel_unit
    import riscv_pkg::*;
(
    input  logic [MAX_REGW-1:0] src,
    input  logic                mem_ok,
    input  logic [MAX_REGW-1:0] mem_rd,
    input  logic                wb_ok,
    input  logic [MAX_REGW-1:0] wb_rd,
    output fwd_sel_e            sel
);

    localparam logic [MAX_REGW-1:0] X0 = '0;

    // compare against MEM first, then WB
    always_comb begin
        sel = FWD_RF;
        if (mem_ok && mem_rd != X0 && mem_rd == src) begin
            sel = FWD_MEM;
        end else if (wb_ok && wb_rd != X0 && wb_rd == src) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: load-use stall,
// branch flush, memory freeze and forwarding.
module hazard_sched
    import riscv_pkg::*;
#(
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            ex_branch_taken,
    input  logic            mem_busy,
    output logic            stall_if,
    output logic            stall_id,
    output logic            flush_id,
    output logic            flush_ex,
    output logic            freeze,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    localparam logic [MAX_REGW-1:0] X0 = '0;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    stage_info_t ex_q;
    stage_info_t mem_q;
    stage_info_t wb_q;
    stage_info_t id_info;

    hz_state_e state;
    hz_state_e state_nx;

    logic load_use;
    logic stall;
    logic flush;
    logic bubble;
    logic mem_ok;
    logic wb_ok;

    fwd_sel_e sel_a;
    fwd_sel_e sel_b;

    // fields tracked for completeness but not read here
    logic unused_fields;
    assign unused_fields = ^{ex_q.regwrite,
                             mem_q.rs1, mem_q.rs2,
                             wb_q.rs1, wb_q.rs2,
                             wb_q.memread};

    // widen the ID-stage fields into a stage record
    always_comb begin
        id_info          = '0;
        id_info.valid    = id_valid;
        id_info.rs1      = MAX_REGW'(id_rs1);
        id_info.rs2      = MAX_REGW'(id_rs2);
        id_info.rd       = MAX_REGW'(id_rd);
        id_info.regwrite = id_regwrite;
        id_info.memread  = id_memread;
    end

    assign load_use = id_valid && ex_q.valid
                   && ex_q.memread && ex_q.rd != X0
                   && (ex_q.rd == id_info.rs1
                       || ex_q.rd == id_info.rs2);

    // a taken branch or a load-use both empty EX
    assign bubble = load_use || ex_branch_taken;

    // next state and control outputs; freeze masks all
    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        flush    = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_busy) state_nx = FREEZE;
            end
            FREEZE: begin
                if (!mem_busy) state_nx = RUN;
            end
        endcase
        if (rst_n && !mem_busy) begin
            flush = ex_branch_taken;
            stall = load_use && !ex_branch_taken;
        end
    end

    assign stall_if = stall;
    assign stall_id = stall;
    assign flush_id = flush;
    assign flush_ex = flush;
    assign freeze   = mem_busy;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // advance stage records unless memory holds the pipe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_busy) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= bubble ? '0 : id_info;
        end
    end

    // saturating event counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
            if (flush && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNTW'(1);
            end
        end
    end

    assign mem_ok = mem_q.valid && mem_q.regwrite
                 && !mem_q.memread;
    assign wb_ok  = wb_q.valid && wb_q.regwrite;

    fwd_sel_unit u_fwd_a (
        .src    (ex_q.rs1),
        .mem_ok (mem_ok),
        .mem_rd (mem_q.rd),
        .wb_ok  (wb_ok),
        .wb_rd  (wb_q.rd),
        .sel    (sel_a)
    );

    fwd_sel_unit u_fwd_b (
        .src    (ex_q.rs2),
        .mem_ok (mem_ok),
        .mem_rd (mem_q.rd),
        .wb_ok  (wb_ok),
        .wb_rd  (wb_q.rd),
        .sel    (sel_b)
    );

    assign fwd_a_sel = rst_n ? sel_a : FWD_RF;
    assign fwd_b_sel = rst_n ? sel_b : FWD_RF;

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed
// scenarios then random traffic against a model.
module tb_hazard_sched;

    localparam int REGW = 5;
    localparam int CNTW = 6;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic            id_regwrite;
    logic            id_memread;
    logic            ex_branch_taken;
    logic            mem_busy;
    logic            stall_if;
    logic            stall_id;
    logic            flush_id;
    logic            flush_ex;
    logic            freeze;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    hazard_sched #(.REGW(REGW), .CNTW(CNTW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .flush_id        (flush_id),
        .flush_ex        (flush_ex),
        .freeze          (freeze),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    // instruction as seen by the model in EX/MEM/WB
    typedef struct {
        bit v;
        int rs1;
        int rs2;
        int rd;
        bit rw;
        bit mr;
    } rec_t;

    rec_t m_ex;
    rec_t m_mem;
    rec_t m_wb;
    int   m_sc;
    int   m_fc;
    int   checks = 0;
    int   errors = 0;

    function automatic int fsel(int src);
        if (m_mem.v && m_mem.rw && !m_mem.mr
            && m_mem.rd != 0 && m_mem.rd == src) return 2;
        if (m_wb.v && m_wb.rw
            && m_wb.rd != 0 && m_wb.rd == src) return 1;
        return 0;
    endfunction

    function automatic int sat(int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    // one clock: drive, check at negedge, advance model
    task automatic cyc(input bit rst, input bit v,
                       input int rs1, input int rs2,
                       input int rd, input bit rw,
                       input bit mr, input bit br,
                       input bit busy);
        bit   lu;
        bit   act;
        bit   e_st;
        bit   e_fl;
        int   ea;
        int   eb;
        rec_t nop;
        rec_t idr;
        nop = '{0, 0, 0, 0, 0, 0};
        idr = '{v, rs1, rs2, rd, rw, mr};
        rst_n           = rst;
        id_valid        = v;
        id_rs1          = rs1[REGW-1:0];
        id_rs2          = rs2[REGW-1:0];
        id_rd           = rd[REGW-1:0];
        id_regwrite     = rw;
        id_memread      = mr;
        ex_branch_taken = br;
        mem_busy        = busy;
        #4;
        lu   = v && m_ex.v && m_ex.mr && m_ex.rd != 0
            && (m_ex.rd == rs1 || m_ex.rd == rs2);
        act  = rst && !busy;
        e_st = act && lu && !br;
        e_fl = act && br;
        ea   = rst ? fsel(m_ex.rs1) : 0;
        eb   = rst ? fsel(m_ex.rs2) : 0;
        chk("stall_if", 32'(stall_if), 32'(e_st));
        chk("stall_id", 32'(stall_id), 32'(e_st));
        chk("flush_id", 32'(flush_id), 32'(e_fl));
        chk("flush_ex", 32'(flush_ex), 32'(e_fl));
        chk("freeze", 32'(freeze), 32'(busy));
        chk("fwd_a_sel", 32'(fwd_a_sel), 32'(ea));
        chk("fwd_b_sel", 32'(fwd_b_sel), 32'(eb));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_fc));
        @(posedge clk);
        if (!rst) begin
            m_ex  = nop;
            m_mem = nop;
            m_wb  = nop;
            m_sc  = 0;
            m_fc  = 0;
        end else if (!busy) begin
            if (e_st) m_sc = sat(m_sc);
            if (e_fl) m_fc = sat(m_fc);
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (lu || br) ? nop : idr;
        end
        #1;
    endtask

    initial begin
        m_ex  = '{0, 0, 0, 0, 0, 0};
        m_mem = m_ex;
        m_wb  = m_ex;
        m_sc  = 0;
        m_fc  = 0;
        rst_n = 1'b0;
        id_valid = 1'b0;
        id_rs1 = '0;
        id_rs2 = '0;
        id_rd = '0;
        id_regwrite = 1'b0;
        id_memread = 1'b0;
        ex_branch_taken = 1'b0;
        mem_busy = 1'b0;
        @(posedge clk);
        #1;

        // reset state, freeze follows mem_busy in reset
        cyc(0, 1, 5, 5, 5, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // load x5 then a consumer of x5: one stall
        cyc(1, 1, 0, 0, 5, 1, 1, 0, 0);
        cyc(1, 1, 5, 0, 6, 1, 0, 0, 0);
        cyc(1, 1, 5, 0, 6, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // two writers of x3, consumer rs2=3: MEM wins
        cyc(1, 1, 1, 2, 3, 1, 0, 0, 0);
        cyc(1, 1, 1, 2, 3, 1, 0, 0, 0);
        cyc(1, 1, 4, 3, 8, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // load-use together with a taken branch
        cyc(1, 1, 0, 0, 7, 1, 1, 0, 0);
        cyc(1, 1, 1, 7, 9, 1, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // load-use held off by 3 busy cycles
        cyc(1, 1, 0, 0, 9, 1, 1, 0, 0);
        cyc(1, 1, 9, 0, 2, 1, 0, 0, 1);
        cyc(1, 1, 9, 0, 2, 1, 0, 0, 1);
        cyc(1, 1, 9, 0, 2, 1, 0, 0, 1);
        cyc(1, 1, 9, 0, 2, 1, 0, 0, 0);
        cyc(1, 1, 9, 0, 2, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // branch waiting behind a freeze
        cyc(1, 1, 1, 1, 1, 1, 0, 1, 1);
        cyc(1, 1, 1, 1, 1, 1, 0, 1, 0);

        // x0 never forwards or stalls
        cyc(1, 1, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 4, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // saturate both counters
        for (int i = 0; i < CMAX + 5; i++) begin
            cyc(1, 1, 0, 0, 5, 1, 1, 0, 0);
            cyc(1, 1, 5, 0, 6, 1, 0, 0, 0);
            cyc(1, 1, 5, 0, 6, 1, 0, 0, 0);
        end
        for (int i = 0; i < CMAX + 5; i++) begin
            cyc(1, 1, 1, 2, 3, 1, 0, 1, 0);
        end
        cyc(1, 1, 0, 0, 5, 1, 1, 0, 0);
        cyc(1, 1, 5, 0, 6, 1, 0, 0, 0);

        // reset mid-stall: no leftover bubble or count
        cyc(1, 1, 0, 0, 5, 1, 1, 0, 0);
        cyc(0, 1, 5, 0, 6, 1, 0, 1, 0);
        cyc(1, 1, 5, 0, 6, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // random traffic on a small register range
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(49) != 0,
                $urandom_range(3) != 0,
                int'($urandom_range(4)),
                int'($urandom_range(4)),
                int'($urandom_range(4)),
                $urandom_range(3) != 0,
                $urandom_range(2) == 0,
                $urandom_range(9) == 0,
                $urandom_range(4) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_sched.md
HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
REQ-001 SHALL have parameter REGW, default 5, register-index width.
REQ-002 SHALL have parameter CNTW, default 16, performance-counter width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port id_valid  in  1  ID stage holds a real instruction.
REQ-006 SHALL have ports id_rs1, id_rs2, id_rd  in  REGW each  ID-stage source and destination register indices.
REQ-007 SHALL have ports id_regwrite, id_memread  in  1 each  ID-stage instruction writes rd / is a load.
REQ-008 SHALL have port ex_branch_taken  in  1  branch or jump resolved taken in EX this cycle.
REQ-009 SHALL have port mem_busy  in  1  data memory not ready; the whole pipeline must hold.
REQ-010 SHALL have ports stall_if, stall_id  out  1 each  hold the PC and the IF/ID register.
REQ-011 SHALL have ports flush_id, flush_ex  out  1 each  clear the IF/ID register / insert a bubble into ID/EX.
REQ-012 SHALL have port freeze  out  1  hold all pipeline registers.
REQ-013 SHALL have ports fwd_a_sel, fwd_b_sel  out  2 each  ALU operand mux select: 00 = regfile, 01 = WB result, 10 = MEM result.
REQ-014 SHALL have ports stall_cnt, flush_cnt  out  CNTW each  saturating event counters.

Function
REQ-015 SHALL keep a stage record {valid, rs1, rs2, rd, regwrite, memread} for each of EX, MEM and WB.
REQ-016 Tracking, when not frozen, SHALL advance each edge: WB<=MEM; MEM<=EX; EX<=ID fields, or a bubble (valid=0) on load-use stall or flush.
REQ-017 Load-use hazard SHALL be: id_valid & EX.valid & EX.memread & EX.rd!=0 & (EX.rd==id_rs1 | EX.rd==id_rs2).
REQ-018 Load-use SHALL assert stall_if and stall_id combinationally in the same cycle, insert exactly one EX bubble, and release on the following cycle.
REQ-019 ex_branch_taken SHALL assert flush_id and flush_ex in the same cycle, insert an EX bubble, and deassert stall_if/stall_id; branch overrides load-use.
REQ-020 The FSM SHALL have two states: RUN and FREEZE. RUN->FREEZE on mem_busy=1; FREEZE->RUN on the first cycle with mem_busy=0.
REQ-021 freeze SHALL equal mem_busy combinationally. While mem_busy=1: stall_if/stall_id/flush_id/flush_ex are 0, tracking holds, and counters hold.
REQ-022 A branch or load-use condition present during freeze SHALL be acted on in the first unfrozen cycle.
REQ-023 fwd_a_sel SHALL be 10 if MEM.valid & MEM.regwrite & !MEM.memread & MEM.rd!=0 & MEM.rd==EX.rs1; otherwise 01 if the same test passes for WB (memread ignored); otherwise 00. fwd_b_sel SHALL apply the same rule to EX.rs2.
REQ-024 MEM forwarding SHALL take priority over WB when both match.
REQ-025 Register x0 SHALL never cause a stall or a forward.
REQ-026 stall_cnt SHALL increment on every load-use stall cycle; flush_cnt SHALL increment on every flush cycle; both saturate at all-ones without wrapping.

Reset
REQ-027 With rst_n=0 at an edge, the block SHALL set: all stage valid bits to 0, the FSM to RUN, and both counters to 0.
REQ-028 During and after reset, all outputs SHALL be 0 except freeze, which follows mem_busy.
REQ-029 Reset asserted mid-stall, mid-flush or in FREEZE SHALL abort the operation with no residual bubble.

Structure
REQ-030 A shared package riscv_pkg SHALL hold: fwd_sel_e {FWD_RF=00, FWD_WB=01, FWD_MEM=10}, hz_state_e {RUN, FREEZE}, and stage_info_t.
REQ-031 A single sub-module fwd_sel_unit (one operand's compare and priority logic) SHALL be instantiated twice, once for operand a and once for operand b.

Verification
REQ-032 Load x5 in EX, ID reads rs1=5 -> stall_if=stall_id=1 for exactly 1 cycle, stall_cnt=1; next cycle fwd_a_sel=01 once the load reaches WB.
REQ-033 add x3 in MEM and add x3 in WB, EX rs2=3 -> fwd_b_sel=10 (MEM priority).
REQ-034 Load-use and ex_branch_taken in the same cycle -> flush_id=flush_ex=1, stall_if=0, flush_cnt=1, stall_cnt=0.
REQ-035 mem_busy=1 for 3 cycles during a load-use hazard -> freeze=1, stall_if=0, tracking and counters unchanged; stall asserted in the first cycle after mem_busy drops.
REQ-036 rd=0 with regwrite=1 in MEM and EX rs1=0 -> fwd_a_sel=00, no stall.
REQ-037 Preload stall_cnt to 2^CNTW-1, then force a load-use -> stall_cnt stays 0xFFFF; rst_n=0 for one edge -> both counters 0 and all valid bits 0.
